wide_add_seq: RTL and testbench

- Multi-cycle controller that performs wide add/subtract by time-multiplexing one external WORD_W-bit carry-lookahead adder slice built from 4-bit CLA groups.
- Latches wide operands on a start handshake and presents one word slice per cycle, least significant first.
- Chains the slice carry-out into the next slice carry-in, assembles the result, and flags carry and signed overflow.
- Sits between the lab top-level or operand registers and the shared adder datapath.

---
 rtl/wide_add_seq.sv | 126 ++++++++++++
 tb/tb_wide_add_seq.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/wide_add_seq.sv
// Wide add/subtract controller: feeds one external WORD_W-bit adder slice per
// cycle, LSB slice first, chaining carries and assembling the full result.
module wide_add_seq #(
  parameter int WORD_W    = 16,
  parameter int NUM_WORDS = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        sub,
  input  logic [WORD_W*NUM_WORDS-1:0] a,
  input  logic [WORD_W*NUM_WORDS-1:0] b,
  output logic                        busy,
  output logic                        done,
  output logic [WORD_W*NUM_WORDS-1:0] sum,
  output logic                        cout,
  output logic                        ovf,
  output logic [WORD_W-1:0]           add_a,
  output logic [WORD_W-1:0]           add_b,
  output logic                        add_cin,
  input  logic [WORD_W-1:0]           add_sum,
  input  logic                        add_cout
);

  localparam int TOT_W = WORD_W * NUM_WORDS;
  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [TOT_W-1:0]   opa_q, opa_d;
  logic [TOT_W-1:0]   opb_q, opb_d;
  logic [TOT_W-1:0]   sum_q, sum_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               in_run;

  assign in_run  = (state_q == RUN);
  assign add_a   = in_run ? opa_q[int'(idx_q)*WORD_W +: WORD_W] : '0;
  assign add_b   = in_run ? opb_q[int'(idx_q)*WORD_W +: WORD_W] : '0;
  assign add_cin = in_run ? carry_q : 1'b0;

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      RUN: begin
        sum_d[int'(idx_q)*WORD_W +: WORD_W] = add_sum;
        carry_d = add_cout;
        if (idx_q == LAST_IDX) begin
          // Overflow judged on the effective operands, so subtract uses ~b.
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          idx_d   = '0;
          cout_d  = add_cout;
          ovf_d   = (opa_q[TOT_W-1] == opb_q[TOT_W-1]) &&
                    (add_sum[WORD_W-1] != opa_q[TOT_W-1]);
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: begin
        // IDLE and DONE both accept a new request, giving back-to-back ops.
        if (start) begin
          state_d = RUN;
          opa_d   = a;
          opb_d   = sub ? ~b : b;
          carry_d = sub;
          idx_d   = '0;
          sum_d   = '0;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_wide_add_seq.sv
// Bench for wide_add_seq: combinational slice adder model plus a full-width
// arithmetic reference for sum, carry/no-borrow and signed overflow.
module tb_wide_add_seq;

  localparam int WORD_W    = 16;
  localparam int NUM_WORDS = 4;
  localparam int TOT_W     = WORD_W * NUM_WORDS;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              sub;
  logic [TOT_W-1:0]  a;
  logic [TOT_W-1:0]  b;
  logic              busy;
  logic              done;
  logic [TOT_W-1:0]  sum;
  logic              cout;
  logic              ovf;
  logic [WORD_W-1:0] add_a;
  logic [WORD_W-1:0] add_b;
  logic              add_cin;
  logic [WORD_W-1:0] add_sum;
  logic              add_cout;

  int n_checks;
  int n_pass;
  logic cin_seen [NUM_WORDS];

  wide_add_seq #(.WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout)
  );

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{WORD_W{1'b0}}, add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns {ovf, cout, sum} from plain full-width arithmetic.
  function automatic logic [TOT_W+1:0] ref_op(input logic s, input logic [TOT_W-1:0] av,
                                              input logic [TOT_W-1:0] bv);
    logic [TOT_W:0]   full;
    logic [TOT_W-1:0] r;
    logic             c, v;
    if (s) begin
      full = {1'b0, av} - {1'b0, bv};
      r    = full[TOT_W-1:0];
      c    = (av >= bv);
      v    = (av[TOT_W-1] != bv[TOT_W-1]) && (r[TOT_W-1] != av[TOT_W-1]);
    end else begin
      full = {1'b0, av} + {1'b0, bv};
      r    = full[TOT_W-1:0];
      c    = full[TOT_W];
      v    = (av[TOT_W-1] == bv[TOT_W-1]) && (r[TOT_W-1] != av[TOT_W-1]);
    end
    return {v, c, r};
  endfunction

  task automatic chk(input string tag, input logic [TOT_W-1:0] obs, input logic [TOT_W-1:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic do_op(input string tag, input logic s, input logic [TOT_W-1:0] av,
                       input logic [TOT_W-1:0] bv, input bit poke);
    logic [TOT_W+1:0] r;
    int edges;
    r = ref_op(s, av, bv);
    @(negedge clk);
    start = 1'b1; sub = s; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0; sub = ~s; a = ~av; b = ~bv;
    chk({tag, "_busy_start"}, busy, 1);
    chk({tag, "_sum_cleared"}, sum, 0);
    chk({tag, "_done_low"}, done, 0);
    cin_seen[0] = add_cin;
    edges = 0;
    while (done !== 1'b1 && edges < 20) begin
      if (poke && edges == 1) begin
        start = 1'b1; sub = $urandom_range(0, 1); a = {$urandom, $urandom}; b = {$urandom, $urandom};
      end
      if (poke && edges == 2) start = 1'b0;
      @(posedge clk); #1;
      edges++;
      if (edges < NUM_WORDS) cin_seen[edges] = add_cin;
    end
    start = 1'b0;
    chk({tag, "_latency"}, edges, NUM_WORDS);
    chk({tag, "_busy_done"}, busy, 0);
    chk({tag, "_sum"}, sum, r[TOT_W-1:0]);
    chk({tag, "_cout"}, cout, r[TOT_W]);
    chk({tag, "_ovf"}, ovf, r[TOT_W+1]);
  endtask

  task automatic after_done(input string tag, input logic [TOT_W-1:0] exp_sum);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_idle_busy"}, busy, 0);
    chk({tag, "_sum_hold"}, sum, exp_sum);
    chk({tag, "_idle_slice"}, {add_cin, add_a, add_b}, 0);
  endtask

  initial begin
    logic [TOT_W+1:0] r;
    logic [TOT_W-1:0] ra, rb;
    logic rs;
    logic saw_done;
    n_checks = 0;
    n_pass   = 0;
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_flags", {cout, ovf}, 0);
    chk("rst_slice", {add_cin, add_a, add_b}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("carry", 1'b0, 64'h0000_0000_0000_FFFF, 64'h1, 1'b0);
    chk("carry_exact", sum, 64'h0000_0000_0001_0000);
    after_done("carry", 64'h0000_0000_0001_0000);

    do_op("ripple", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
    chk("ripple_cin", {cin_seen[1], cin_seen[2], cin_seen[3]}, 3'b111);
    chk("ripple_cin0", cin_seen[0], 0);
    after_done("ripple", 64'h0);

    do_op("borrow", 1'b1, 64'h5, 64'h7, 1'b0);
    chk("borrow_cin0", cin_seen[0], 1);
    chk("borrow_exact", sum, 64'hFFFF_FFFF_FFFF_FFFE);
    after_done("borrow", 64'hFFFF_FFFF_FFFF_FFFE);

    do_op("ovf_add", 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
    chk("ovf_add_flag", ovf, 1);
    after_done("ovf_add", 64'h8000_0000_0000_0000);
    do_op("ovf_sub", 1'b1, 64'h8000_0000_0000_0000, 64'h1, 1'b0);
    chk("ovf_sub_flag", ovf, 1);
    after_done("ovf_sub", 64'h7FFF_FFFF_FFFF_FFFF);

    do_op("ignore", 1'b0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1);
    after_done("ignore", 64'h2222_2222_2222_2211);

    // Second op is driven inside the done cycle of the first: no idle gap.
    do_op("b2b_first", 1'b0, 64'h1111, 64'h2222, 1'b0);
    do_op("b2b_second", 1'b1, 64'h10, 64'h3, 1'b0);
    after_done("b2b_second", 64'hD);

    for (int i = 0; i < 8; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rs = 1'($urandom_range(0, 1));
      if (i == 0) rb = ra;
      r = ref_op(rs, ra, rb);
      do_op($sformatf("rand%0d", i), rs, ra, rb, 1'b0);
      after_done($sformatf("rand%0d", i), r[TOT_W-1:0]);
    end

    @(negedge clk);
    start = 1'b1; sub = 1'b0; a = 64'hAAAA_BBBB_CCCC_DDDD; b = 64'h1111_2222_3333_4444;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_sum", sum, 0);
    chk("midrst_done", done, 0);
    chk("midrst_slice", {add_cin, add_a, add_b}, 0);
    saw_done = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      saw_done |= done;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      saw_done |= done;
    end
    chk("midrst_no_done", saw_done, 0);
    chk("midrst_idle_busy", busy, 0);

    do_op("fresh", 1'b0, 64'h3, 64'h4, 1'b0);
    chk("fresh_exact", sum, 64'h7);
    after_done("fresh", 64'h7);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
